// File: rtl/lfsr_gen.sv
`default_nettype none
// ============================================================================
// Module   : lfsr_gen
// Purpose  : Fibonacci/Galois LFSR with free-run, bounded burst, seed load,
//            all-zero lockup recovery and seed-return (wrap) detection.
// Revision : 1.0 - initial release
// ============================================================================
module lfsr_gen #(
    parameter int               WIDTH = 4,
    parameter logic [WIDTH-1:0] FTAPS = WIDTH'(4'b1100),
    parameter logic [WIDTH-1:0] GTAPS = WIDTH'(4'b0011),
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             mode,
    input  logic             load,
    input  logic [WIDTH-1:0] seed_in,
    input  logic             start,
    input  logic [15:0]      steps,
    output logic [WIDTH-1:0] data_out,
    output logic             busy,
    output logic             done,
    output logic             lockup,
    output logic             wrap
);

    // State holds the seed from time zero so data_out is defined before any edge.
    logic [WIDTH-1:0] r_state = SEED;
    logic [WIDTH-1:0] r_ref   = SEED;
    logic [15:0]      r_cnt;
    logic             r_busy;
    logic             r_done;
    logic             r_wrap;

    logic [WIDTH-1:0] w_fib;
    logic [WIDTH-1:0] w_gal;
    logic [WIDTH-1:0] w_next;
    logic             w_zero;

    // Next-state polynomial; an all-zero state would stick, so it restarts at SEED.
    always_comb begin
        w_zero = (r_state == '0);
        w_fib  = {r_state[WIDTH-2:0], ^(r_state & FTAPS)};
        w_gal  = {r_state[WIDTH-2:0], 1'b0} ^ (r_state[WIDTH-1] ? GTAPS : '0);
        w_next = w_zero ? SEED : (mode ? w_gal : w_fib);
    end

    // Control and state register: reset, then load, then burst/start, then free run.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= SEED;
            r_ref   <= SEED;
            r_cnt   <= 16'd0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_wrap  <= 1'b0;
        end else if (load) begin
            // Load aborts any burst silently and re-arms wrap detection on the new seed.
            r_state <= seed_in;
            r_ref   <= seed_in;
            r_cnt   <= 16'd0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_wrap  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_wrap <= 1'b0;
            if (r_busy) begin
                r_state <= w_next;
                r_wrap  <= (w_next == r_ref);
                if (r_cnt <= 16'd1) begin
                    r_cnt  <= 16'd0;
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end else begin
                    r_cnt <= r_cnt - 16'd1;
                end
            end else if (start) begin
                // The accepting cycle only latches the length; advances begin next cycle.
                if (steps == 16'd0) begin
                    r_done <= 1'b1;
                end else begin
                    r_busy <= 1'b1;
                    r_cnt  <= steps;
                end
            end else if (en) begin
                r_state <= w_next;
                r_wrap  <= (w_next == r_ref);
            end
        end
    end

    assign data_out = r_state;
    assign busy     = r_busy;
    assign done     = r_done;
    assign wrap     = r_wrap;
    assign lockup   = w_zero;

endmodule
`default_nettype wire

// File: tb/tb_lfsr_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_lfsr_gen
// Purpose  : Self-checking bench for lfsr_gen against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lfsr_gen;

    localparam logic [3:0] FT = 4'b1100;
    localparam logic [3:0] GT = 4'b0011;
    localparam logic [3:0] SD = 4'd1;

    logic       clk = 1'b0;
    logic       rst, en, mode, load, start;
    logic [3:0] seed_in;
    logic [15:0] steps;
    logic [3:0] data_out;
    logic       busy, done, lockup, wrap;

    int tests = 0;
    int fails = 0;

    // Behavioural model state
    logic [3:0] m_state = SD;
    logic [3:0] m_ref   = SD;
    bit         m_busy  = 0;
    bit         m_done  = 0;
    bit         m_wrap  = 0;
    int         m_rem   = 0;

    lfsr_gen #(.WIDTH(4), .FTAPS(FT), .GTAPS(GT), .SEED(SD)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .load(load),
        .seed_in(seed_in), .start(start), .steps(steps),
        .data_out(data_out), .busy(busy), .done(done),
        .lockup(lockup), .wrap(wrap)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Fibonacci step as shift-by-doubling plus tap parity
    function automatic logic [3:0] fib(input logic [3:0] s);
        int v;
        v = ((int'(s) * 2) % 16) + ($countones(s & FT) % 2);
        return 4'(v);
    endfunction

    // Galois step as doubling, reduced by the tap mask on carry-out
    function automatic logic [3:0] gal(input logic [3:0] s);
        int v;
        v = (int'(s) * 2) % 16;
        if (s >= 4'd8) v = v ^ int'(GT);
        return 4'(v);
    endfunction

    task automatic model_advance();
        if (m_state == 4'd0) m_state = SD;
        else m_state = mode ? gal(m_state) : fib(m_state);
        m_wrap = (m_state == m_ref);
    endtask

    // Model update on each rising edge, then compare every output just after it
    always @(posedge clk) begin
        if (!rst) begin
            m_state = SD; m_ref = SD; m_busy = 0; m_done = 0; m_wrap = 0; m_rem = 0;
        end else if (load) begin
            m_state = seed_in; m_ref = seed_in; m_busy = 0; m_done = 0; m_wrap = 0; m_rem = 0;
        end else begin
            m_done = 0;
            m_wrap = 0;
            if (m_busy) begin
                model_advance();
                m_rem = m_rem - 1;
                if (m_rem == 0) begin
                    m_busy = 0;
                    m_done = 1;
                end
            end else if (start) begin
                if (steps == 16'd0) m_done = 1;
                else begin
                    m_busy = 1;
                    m_rem  = int'(steps);
                end
            end else if (en) begin
                model_advance();
            end
        end
        #1;
        chk("cmp_data_out", data_out, m_state);
        chk("cmp_busy", busy, m_busy);
        chk("cmp_done", done, m_done);
        chk("cmp_wrap", wrap, m_wrap);
        chk("cmp_lockup", lockup, (m_state == 4'd0));
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] fib_exp [6];
        logic [3:0] gal_exp [5];
        int wraps, first_ret, busy_cnt, done_cnt;
        bit done_seen;
        fib_exp = '{4'h1, 4'h2, 4'h4, 4'h9, 4'h3, 4'h6};
        gal_exp = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h3};

        rst = 0; en = 0; mode = 0; load = 0; seed_in = 0; start = 0; steps = 0;
        #1 chk("pre_edge_seed", data_out, 4'h1);
        tick(2);
        chk("rst_data", data_out, 4'h1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_wrap", wrap, 0);
        chk("rst_lockup", lockup, 0);

        // Fibonacci free run
        rst = 1; en = 1; mode = 0; wraps = 0;
        for (int i = 1; i <= 15; i++) begin
            tick(1);
            if (i <= 5) chk("fib_seq", data_out, fib_exp[i]);
            wraps += int'(wrap);
        end
        chk("fib_wrap_state", data_out, 4'h1);
        chk("fib_wrap_pulse", wrap, 1);
        chk("fib_wrap_count", wraps, 1);
        en = 0;
        tick(1);
        chk("wrap_one_cycle", wrap, 0);
        chk("hold_when_idle", data_out, 4'h1);

        // Galois free run
        rst = 0; tick(1); rst = 1;
        mode = 1; en = 1; wraps = 0; first_ret = 0;
        for (int i = 1; i <= 15; i++) begin
            tick(1);
            if (i <= 4) chk("gal_seq", data_out, gal_exp[i]);
            if (data_out == 4'h1 && first_ret == 0) first_ret = i;
            wraps += int'(wrap);
        end
        chk("gal_period", first_ret, 15);
        chk("gal_wrap_count", wraps, 1);
        en = 0; mode = 0;

        // Burst of 3
        rst = 0; tick(1); rst = 1;
        start = 1; steps = 16'd3; tick(1); start = 0;
        busy_cnt = int'(busy); done_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            busy_cnt += int'(busy);
            done_cnt += int'(done);
        end
        chk("burst3_busy_cycles", busy_cnt, 3);
        chk("burst3_done_count", done_cnt, 1);
        chk("burst3_final", data_out, 4'h9);

        // Load zero, lockup, recovery
        load = 1; seed_in = 4'h0; tick(1); load = 0;
        chk("load0_data", data_out, 4'h0);
        chk("load0_lockup", lockup, 1);
        en = 1; tick(1); en = 0;
        chk("recover_data", data_out, 4'h1);
        chk("recover_lockup", lockup, 0);
        chk("recover_nowrap", wrap, 0);

        // Load aborting a burst
        rst = 0; tick(1); rst = 1;
        start = 1; steps = 16'd10; tick(1); start = 0;
        tick(3);
        load = 1; seed_in = 4'h5; tick(1); load = 0;
        chk("abort_data", data_out, 4'h5);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        tick(1);
        chk("abort_no_late_done", done, 0);

        // Start/en ignored while busy
        start = 1; steps = 16'd5; tick(1);
        busy_cnt = int'(busy);
        steps = 16'd0; en = 1; tick(1); start = 0;
        busy_cnt += int'(busy);
        done_seen = 0;
        for (int k = 0; k < 20 && !done_seen; k++) begin
            tick(1);
            busy_cnt += int'(busy);
            if (done) done_seen = 1;
        end
        en = 0;
        chk("burst5_done_seen", done_seen, 1);
        chk("burst5_busy_cycles", busy_cnt, 5);
        chk("burst5_final", data_out, 4'hC);

        // Zero-length burst
        start = 1; steps = 16'd0; tick(1); start = 0;
        chk("zero_done", done, 1);
        chk("zero_busy", busy, 0);
        chk("zero_data", data_out, 4'hC);
        tick(1);
        chk("zero_done_pulse", done, 0);

        // Reset mid-burst
        start = 1; steps = 16'd10; tick(1); start = 0;
        tick(1);
        rst = 0; tick(1); rst = 1;
        chk("midrst_data", data_out, 4'h1);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        done_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            tick(1);
            done_cnt += int'(done);
        end
        chk("midrst_no_done", done_cnt, 0);

        // Randomised traffic checked by the model every cycle
        for (int i = 0; i < 3000; i++) begin
            rst     = ($urandom_range(0, 199) != 0);
            load    = ($urandom_range(0, 39) == 0);
            start   = ($urandom_range(0, 14) == 0);
            en      = $urandom_range(0, 1) == 1;
            mode    = $urandom_range(0, 1) == 1;
            seed_in = 4'($urandom_range(0, 15));
            steps   = ($urandom_range(0, 5) == 0) ? 16'd0 : 16'($urandom_range(1, 20));
            tick(1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
